// File: rtl/fifo_wr_arb.sv
// Round-robin packet arbiter feeding one FIFO write port; the winner owns the port until its last word.
// Write word/enable are registered (1-cycle latency); ready drops while the tracked FIFO occupancy is full.
module fifo_wr_arb #(
   parameter int DATAWIDTH = 8,
   parameter int NREQ      = 4,
   parameter int DEPTH     = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NREQ-1:0]               req_valid,
   input  logic [NREQ*DATAWIDTH-1:0]     req_data,
   input  logic [NREQ-1:0]               req_last,
   output logic [NREQ-1:0]               req_ready,
   output logic [DATAWIDTH-1:0]          fifo_wr_data,
   output logic                          fifo_we,
   input  logic                          fifo_re,
   output logic [$clog2(NREQ)-1:0]       grant_id,
   output logic                          busy,
   output logic [$clog2(DEPTH):0]        count,
   output logic                          err
);

   localparam int GW = $clog2(NREQ);
   localparam int CW = $clog2(DEPTH) + 1;

   typedef enum logic {IDLE, OWN} state_t;

   state_t                 state_q, state_d;
   logic [GW-1:0]          last_q, last_d;
   logic [GW-1:0]          gid_q, gid_d;
   logic                   we_q, we_d;
   logic [DATAWIDTH-1:0]   data_q, data_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   err_q, err_d;
   logic                   accept;
   logic                   full;

   // First valid requester strictly after 'last', wrapping past NREQ-1 to 0.
   function automatic logic [GW-1:0] rr_pick(input logic [NREQ-1:0] v, input logic [GW-1:0] last);
      logic [2*NREQ-1:0] rot;
      int                off;
      int                idx;
      rot = {v, v} >> (int'(last) + 1);
      off = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rot[k]) off = k;
      end
      idx = int'(last) + 1 + off;
      if (idx >= NREQ) idx = idx - NREQ;
      return GW'(idx);
   endfunction

   assign full = (cnt_q == CW'(DEPTH));

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      gid_d     = gid_q;
      req_ready = '0;
      accept    = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req_valid) begin
               gid_d   = rr_pick(req_valid, last_q);
               state_d = OWN;
            end
         end
         OWN: begin
            req_ready[gid_q] = !full;
            accept           = req_valid[gid_q] && !full;
            if (accept && req_last[gid_q]) begin
               last_d  = gid_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      we_d   = accept;
      data_d = accept ? req_data[gid_q*DATAWIDTH +: DATAWIDTH] : data_q;
   end

   // A read on an empty FIFO is an error, but a same-cycle write still counts.
   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (fifo_re && (cnt_q == '0)) begin
         err_d = 1'b1;
         if (accept) cnt_d = cnt_q + CW'(1);
      end else if (accept && !fifo_re) begin
         cnt_d = cnt_q + CW'(1);
      end else if (!accept && fifo_re) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         last_q  <= GW'(NREQ - 1);
         gid_q   <= '0;
         we_q    <= 1'b0;
         data_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         gid_q   <= gid_d;
         we_q    <= we_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign fifo_we      = we_q;
   assign fifo_wr_data = data_q;
   assign grant_id     = gid_q;
   assign busy         = (state_q == OWN);
   assign count        = cnt_q;
   assign err          = err_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed scenarios plus random traffic against a cycle-level reference model.
module tb_fifo_wr_arb;

   localparam int DW    = 8;
   localparam int NREQ  = 4;
   localparam int DEPTH = 16;

   logic                  clk;
   logic                  reset;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*DW-1:0]    req_data;
   logic [NREQ-1:0]       req_last;
   logic [NREQ-1:0]       req_ready;
   logic [DW-1:0]         fifo_wr_data;
   logic                  fifo_we;
   logic                  fifo_re;
   logic [1:0]            grant_id;
   logic                  busy;
   logic [4:0]            count;
   logic                  err;

   fifo_wr_arb #(.DATAWIDTH(DW), .NREQ(NREQ), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
      .fifo_wr_data(fifo_wr_data), .fifo_we(fifo_we), .fifo_re(fifo_re),
      .grant_id(grant_id), .busy(busy), .count(count), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Reference model: owner -1 means nobody holds the write port.
   int            m_owner, m_last, m_gid, m_cnt;
   bit            m_err, m_we, m_ok;
   logic [DW-1:0] m_data;

   task automatic model_step(input logic [NREQ-1:0] v, input logic [NREQ*DW-1:0] d,
                             input logic [NREQ-1:0] l, input logic re, input logic rst);
      bit acc;
      int n_cnt;
      if (rst) begin
         m_owner = -1; m_last = NREQ - 1; m_gid = 0; m_cnt = 0;
         m_err = 0; m_we = 0; m_data = '0; m_ok = 1;
         return;
      end
      acc   = (m_owner >= 0) && (m_cnt < DEPTH) && v[m_owner];
      n_cnt = m_cnt + (acc ? 1 : 0) - ((re && m_cnt > 0) ? 1 : 0);
      if (re && m_cnt == 0) m_err = 1;
      m_we = acc;
      if (acc) m_data = d[m_owner*DW +: DW];
      if (m_owner < 0) begin
         for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (m_last + k) % NREQ;
            if (v[idx]) begin
               m_owner = idx;
               m_gid   = idx;
               break;
            end
         end
      end else if (acc && l[m_owner]) begin
         m_last  = m_owner;
         m_owner = -1;
      end
      m_cnt = n_cnt;
   endtask

   // One clock: compare DUT to model, apply inputs, advance model, land #1 after the edge.
   task automatic cyc(input logic [NREQ-1:0] v, input logic [NREQ*DW-1:0] d,
                      input logic [NREQ-1:0] l, input logic re, input logic rst);
      logic [NREQ-1:0] e_rdy;
      if (m_ok) begin
         e_rdy = (m_owner >= 0 && m_cnt < DEPTH) ? (NREQ'(1) << m_owner) : '0;
         chk("ready", 32'(req_ready), 32'(e_rdy));
         chk("busy", 32'(busy), 32'(m_owner >= 0));
         chk("grant", 32'(grant_id), 32'(m_gid));
         chk("we", 32'(fifo_we), 32'(m_we));
         chk("wdata", 32'(fifo_wr_data), 32'(m_data));
         chk("count", 32'(count), 32'(m_cnt));
         chk("err", 32'(err), 32'(m_err));
      end
      req_valid = v; req_data = d; req_last = l; fifo_re = re; reset = rst;
      model_step(v, d, l, re, rst);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [NREQ*DW-1:0] lane(input int i, input logic [DW-1:0] w);
      logic [NREQ*DW-1:0] r;
      r = '0;
      r[i*DW +: DW] = w;
      return r;
   endfunction

   logic [NREQ*DW-1:0] lanes_a;
   logic [DW-1:0]      got_q[$];
   logic [DW-1:0]      exp_rr[4];
   int                 sent;
   bit                 acc_now;

   initial begin
      m_ok = 0;
      req_valid = '0; req_data = '0; req_last = '0; fifo_re = 1'b0; reset = 1'b1;
      lanes_a = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      #2;
      cyc('0, '0, '0, 1'b0, 1'b1);
      chk("rst_count", 32'(count), 0);
      chk("rst_we", 32'(fifo_we), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ready", 32'(req_ready), 0);

      // Single packet from requester 1
      cyc(4'b0010, lane(1, 8'h11), '0, 1'b0, 1'b0);
      chk("sp_gid", 32'(grant_id), 1);
      chk("sp_busy", 32'(busy), 1);
      cyc(4'b0010, lane(1, 8'h11), '0, 1'b0, 1'b0);
      chk("sp_w0", 32'({fifo_we, fifo_wr_data}), 32'h111);
      cyc(4'b0010, lane(1, 8'h22), '0, 1'b0, 1'b0);
      chk("sp_w1", 32'({fifo_we, fifo_wr_data}), 32'h122);
      cyc(4'b0010, lane(1, 8'h33), 4'b0010, 1'b0, 1'b0);
      chk("sp_w2", 32'({fifo_we, fifo_wr_data}), 32'h133);
      chk("sp_busy_end", 32'(busy), 0);
      chk("sp_count", 32'(count), 3);
      cyc('0, '0, '0, 1'b0, 1'b0);
      chk("sp_we_off", 32'(fifo_we), 0);

      // Round-robin: 0 and 2, then 0,2,3 with wrap
      cyc('0, '0, '0, 1'b0, 1'b1);
      got_q.delete();
      for (int c = 0; c < 6; c++) begin
         cyc(4'b0101, lanes_a, 4'b0101, 1'b0, 1'b0);
         if (fifo_we) got_q.push_back(fifo_wr_data);
      end
      exp_rr = '{8'hA0, 8'hA2, 8'hA0, 8'hA2};
      for (int i = 0; i < 2; i++) chk("rr02", 32'(got_q[i]), 32'(exp_rr[i]));
      cyc('0, '0, '0, 1'b0, 1'b1);
      got_q.delete();
      for (int c = 0; c < 8; c++) begin
         cyc(4'b1101, lanes_a, 4'b1101, 1'b0, 1'b0);
         if (fifo_we) got_q.push_back(fifo_wr_data);
      end
      exp_rr = '{8'hA0, 8'hA2, 8'hA3, 8'hA0};
      for (int i = 0; i < 4; i++) chk("rr023", 32'(got_q[i]), 32'(exp_rr[i]));

      // Full: 20-word packet, no reads
      cyc('0, '0, '0, 1'b0, 1'b1);
      sent = 0;
      for (int c = 0; c < 24; c++) begin
         acc_now = req_ready[0];
         cyc(4'b0001, lane(0, DW'(sent)), 4'(sent == 19), 1'b0, 1'b0);
         if (acc_now) sent++;
      end
      chk("full_sent", 32'(sent), 16);
      chk("full_count", 32'(count), 16);
      chk("full_ready", 32'(req_ready), 0);
      acc_now = req_ready[0];
      cyc(4'b0001, lane(0, DW'(sent)), '0, 1'b1, 1'b0);
      if (acc_now) sent++;
      chk("full_rd_count", 32'(count), 15);
      acc_now = req_ready[0];
      cyc(4'b0001, lane(0, DW'(sent)), '0, 1'b0, 1'b0);
      if (acc_now) sent++;
      chk("full_refill", 32'(sent), 17);
      chk("full_count2", 32'(count), 16);

      // Write and read in the same cycle at count 5
      cyc('0, '0, '0, 1'b0, 1'b1);
      for (int c = 0; c < 6; c++) cyc(4'b0001, lane(0, DW'(c)), '0, 1'b0, 1'b0);
      chk("sim_pre", 32'(count), 5);
      cyc(4'b0001, lane(0, 8'h55), '0, 1'b1, 1'b0);
      chk("sim_count", 32'(count), 5);

      // Underflow
      cyc('0, '0, '0, 1'b0, 1'b1);
      cyc('0, '0, '0, 1'b1, 1'b0);
      chk("uf_count", 32'(count), 0);
      chk("uf_err", 32'(err), 1);
      cyc(4'b0001, lane(0, 8'h77), '0, 1'b0, 1'b0);
      cyc(4'b0001, lane(0, 8'h77), 4'b0001, 1'b1, 1'b0);
      chk("uf_acc_count", 32'(count), 1);
      chk("uf_sticky", 32'(err), 1);
      cyc('0, '0, '0, 1'b0, 1'b1);
      chk("uf_clear", 32'(err), 0);

      // Reset in the middle of a packet from requester 2
      cyc(4'b0100, lane(2, 8'hC0), '0, 1'b0, 1'b0);
      cyc(4'b0100, lane(2, 8'hC0), '0, 1'b0, 1'b0);
      cyc(4'b0100, lane(2, 8'hC1), '0, 1'b0, 1'b0);
      cyc(4'b0100, lane(2, 8'hC2), '0, 1'b0, 1'b1);
      chk("mid_we", 32'(fifo_we), 0);
      chk("mid_data", 32'(fifo_wr_data), 0);
      chk("mid_count", 32'(count), 0);
      chk("mid_busy", 32'(busy), 0);
      cyc(4'b1111, lanes_a, '0, 1'b0, 1'b0);
      chk("mid_regrant", 32'(grant_id), 0);

      // Random traffic, alternating write-heavy and read-heavy phases
      for (int p = 0; p < 6; p++) begin
         for (int c = 0; c < 500; c++) begin
            logic [NREQ*DW-1:0] d;
            int                 rp;
            for (int i = 0; i < NREQ; i++) d[i*DW +: DW] = DW'($urandom);
            rp = (p % 2 == 0) ? 8 : 2;
            cyc(NREQ'($urandom), d, NREQ'($urandom & $urandom),
                ($urandom % rp) == 0, ($urandom % 300) == 0);
         end
      end
      cyc('0, '0, '0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 8, width of each write word.
REQ-002 The block SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-003 The block SHALL have parameter DEPTH, default 16, downstream FIFO depth in words (power of 2).
REQ-004 Port clk  input  1  sole clock; all logic on rising edge.
REQ-005 Port reset  input  1  one clock; reset is synchronous and active-high.
REQ-006 Port req_valid  input  NREQ  per-requester word valid.
REQ-007 Port req_data  input  NREQ*DATAWIDTH  requester i word in bits [i*DATAWIDTH +: DATAWIDTH].
REQ-008 Port req_last  input  NREQ  marks final word of requester's packet.
REQ-009 Port req_ready  output  NREQ  word accepted when valid&ready on same edge.
REQ-010 Port fifo_wr_data  output  DATAWIDTH  registered write data to FIFO.
REQ-011 Port fifo_we  output  1  registered write enable to FIFO.
REQ-012 Port fifo_re  input  1  copy of FIFO read enable, used for occupancy tracking.
REQ-013 Port grant_id  output  $clog2(NREQ)  index of current owner.
REQ-014 Port busy  output  1  high while a packet owns the FIFO write port.
REQ-015 Port count  output  $clog2(DEPTH)+1  accepted-but-unread word count.
REQ-016 Port err  output  1  sticky: fifo_re seen with count==0.

Function
REQ-017 States SHALL be IDLE and OWN; busy = (state==OWN).
REQ-018 IDLE: if any req_valid, select first valid index after last_grant, wrapping (round-robin), load grant_id, go OWN next edge; req_ready all zero in IDLE.
REQ-019 OWN: req_ready[grant_id] = (count != DEPTH); all other req_ready bits 0.
REQ-020 Acceptance SHALL drive fifo_we=1 and fifo_wr_data=accepted word on the following edge (1-cycle latency); otherwise fifo_we=0, fifo_wr_data holds.
REQ-021 Acceptance with req_last=1 SHALL set last_grant=grant_id and return to IDLE next edge; no word from another requester is accepted in that next cycle.
REQ-022 Owner may drop req_valid mid-packet; ownership SHALL persist until its req_last word is accepted (no preemption).
REQ-023 count SHALL +1 on acceptance without fifo_re, -1 on fifo_re without acceptance (count>0), unchanged when both occur.
REQ-024 fifo_re with count==0 SHALL leave count at 0 and set err; simultaneous acceptance then SHALL still +1.
REQ-025 count==DEPTH SHALL deassert req_ready; simultaneous fifo_re does not re-enable ready in that same cycle.
REQ-026 Round-robin wrap: with last_grant=NREQ-1, search starts at index 0.

Reset
REQ-027 On reset: state=IDLE, last_grant=NREQ-1, grant_id=0, req_ready=0, fifo_we=0, fifo_wr_data=0, count=0, err=0, busy=0.
REQ-028 Reset mid-packet SHALL abandon the packet; any word accepted on the reset edge is discarded (fifo_we=0 next cycle).

Verification
REQ-029 Single packet: req 1 sends 0x11,0x22,0x33(last) -> grant_id=1 one cycle after valid; fifo_we high 3 cycles carrying 0x11,0x22,0x33; busy drops after last; count=3.
REQ-030 Round-robin: req 0 and 2 valid together after reset, 1-word packets -> order 0 then 2; repeat with 0,2,3 valid -> order 0,2,3, then wrap to 0.
REQ-031 Full: DEPTH=16, 20-word packet, no reads -> exactly 16 accepted, req_ready low at count=16; one fifo_re -> count 15, one more word accepted next cycle.
REQ-032 Simultaneous: acceptance and fifo_re same cycle at count=5 -> count stays 5.
REQ-033 Underflow: fifo_re at count=0 -> count 0, err=1 until reset.
REQ-034 Reset mid-packet: reset asserted after 2 of 4 words -> all outputs at reset values next cycle; new request re-arbitrated from index 0.
